// File: rtl/gate_pulse_gen.sv
// gate_pulse_gen: programmable periodic/single-shot gate window generator with edge strobes and cycle count.
// Define GATE_PULSE_GEN_TICK_EN to add the free-running divided tick output.
module gate_pulse_gen #(
  parameter int CNT_W    = 32,
  parameter int HIGH_DEF = 50000000,
  parameter int LOW_DEF  = 50000000,
  parameter int TICK_DIV = 100000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic             start,
  input  logic             load,
  input  logic [CNT_W-1:0] high_len,
  input  logic [CNT_W-1:0] low_len,
  output logic             gate,
  output logic             gate_rise,
  output logic             gate_fall,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cnt,
  output logic             tick
);
  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
  state_t state;
  logic [CNT_W-1:0] sh_hi, sh_lo, hi_act, lo_act, hi_end, lo_end;
  if (TICK_DIV < 2) begin : g_bad_div
    $error("TICK_DIV must be at least 2");
  end
  // a zero length behaves as one cycle, so the last index is clamped at 0
  assign hi_end = (hi_act == '0) ? '0 : hi_act - CNT_W'(1);
  assign lo_end = (lo_act == '0) ? '0 : lo_act - CNT_W'(1);
  assign busy = (state != IDLE);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      gate      <= 1'b0;
      gate_rise <= 1'b0;
      gate_fall <= 1'b0;
      done      <= 1'b0;
      cnt       <= '0;
      sh_hi     <= CNT_W'(HIGH_DEF);
      sh_lo     <= CNT_W'(LOW_DEF);
      hi_act    <= CNT_W'(HIGH_DEF);
      lo_act    <= CNT_W'(LOW_DEF);
    end else begin
      gate_rise <= 1'b0;
      gate_fall <= 1'b0;
      done      <= 1'b0;
      if (load) begin
        sh_hi <= high_len;
        sh_lo <= low_len;
      end
      case (state)
        IDLE: if (en && (!mode || start)) begin
          state     <= HIGH;
          gate      <= 1'b1;
          gate_rise <= 1'b1;
          cnt       <= '0;
          hi_act    <= load ? high_len : sh_hi;
          lo_act    <= load ? low_len : sh_lo;
        end
        HIGH: if (!en) begin
          state <= IDLE;
          gate  <= 1'b0;
          cnt   <= '0;
        end else if (cnt == hi_end) begin
          state     <= LOW;
          gate      <= 1'b0;
          gate_fall <= 1'b1;
          cnt       <= '0;
        end else cnt <= cnt + CNT_W'(1);
        LOW: if (!en) begin
          state <= IDLE;
          cnt   <= '0;
        end else if (cnt == lo_end) begin
          cnt <= '0;
          if (mode) begin
            state <= IDLE;
            done  <= 1'b1;
          end else begin
            state     <= HIGH;
            gate      <= 1'b1;
            gate_rise <= 1'b1;
            hi_act    <= sh_hi;
            lo_act    <= sh_lo;
          end
        end else cnt <= cnt + CNT_W'(1);
        default: state <= IDLE;
      endcase
    end
  end
`ifdef GATE_PULSE_GEN_TICK_EN
  localparam int TW = $clog2(TICK_DIV);
  logic [TW-1:0] div;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div  <= '0;
      tick <= 1'b0;
    end else begin
      div  <= (div == TW'(TICK_DIV - 1)) ? '0 : div + TW'(1);
      tick <= (div == TW'(TICK_DIV - 1));
    end
  end
`else
  assign tick = 1'b0;
`endif
endmodule
